// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared header field offsets and state encoding for the output-port-lookup pipeline
// Purpose: TDATA head-beat field positions, the minimum forwardable TTL and the
//          HEAD/BODY packet state used by the header rewrite stage.
// Ports:   none (package).
package router_pkg;

  localparam int MAC_W    = 48;
  localparam int DMAC_LO  = 208;  // dst MAC occupies [255:208]
  localparam int SMAC_LO  = 160;  // src MAC occupies [207:160]
  localparam int TTL_LO   = 72;   // TTL occupies [79:72]
  localparam int CKSUM_LO = 48;   // IP header checksum occupies [63:48]

  localparam logic [7:0] TTL_MIN = 8'd1;

  typedef enum logic {
    ST_HEAD = 1'b0,
    ST_BODY = 1'b1
  } hdr_state_e;

endpackage

// File: rtl/nf10_hdr_rewrite_if.sv
// rtl/nf10_hdr_rewrite_if.sv - packet stream bundle between pipeline stages
// Purpose: groups one packet stream (data, strobes, sideband user bits,
//          valid/ready handshake, end-of-packet marker).
// Ports:   master drives tdata/tstrb/tuser/tvalid/tlast and samples tready;
//          slave is the mirror image.
interface nf10_hdr_rewrite_if #(
  parameter int DATA_WIDTH = 256,
  parameter int USER_WIDTH = 128
);

  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic [USER_WIDTH-1:0]   tuser;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;

  modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);

endinterface

// File: rtl/fallthrough_small_fifo.sv
// rtl/fallthrough_small_fifo.sv - small show-ahead FIFO
// Purpose: 2**DEPTH_BITS entry FIFO whose head entry is visible on dout while
//          not empty; a pop advances to the next entry on the clock edge.
// Ports:   clk, reset (sync, active-high), wr_en/din push, rd_en pop,
//          dout head entry, nearly_full (count >= PROG_FULL), empty.
module fallthrough_small_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_BITS = 2,
  parameter int PROG_FULL  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             nearly_full,
  output logic             empty
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic [DEPTH_BITS:0]   count;
  logic                  full;
  logic                  do_wr;
  logic                  do_rd;

  assign full        = (count == (DEPTH_BITS+1)'(DEPTH));
  assign empty       = (count == '0);
  assign nearly_full = (count >= (DEPTH_BITS+1)'(PROG_FULL));
  assign do_wr       = wr_en && !full;
  assign do_rd       = rd_en && !empty;
  assign dout        = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + DEPTH_BITS'(1);
      if (do_rd) rd_ptr <= rd_ptr + DEPTH_BITS'(1);
      count <= count + (DEPTH_BITS+1)'(do_wr) - (DEPTH_BITS+1)'(do_rd);
    end
  end

endmodule

// File: rtl/ip_cksum_dec_ttl.sv
// rtl/ip_cksum_dec_ttl.sv - TTL decrement with incremental IPv4 checksum update
// Purpose: lowering TTL by one lowers the header word holding TTL by 0x0100,
//          so the ones'-complement checksum rises by 0x0100 with the carry
//          folded back in. No 0x0000/0xFFFF remapping is applied.
// Ports:   ttl_in/cksum_in original fields, ttl_out/cksum_out updated fields.
module ip_cksum_dec_ttl (
  input  logic [7:0]  ttl_in,
  input  logic [15:0] cksum_in,
  output logic [7:0]  ttl_out,
  output logic [15:0] cksum_out
);

  logic [16:0] sum;

  assign sum       = {1'b0, cksum_in} + 17'h00100;
  // Fold cannot carry again: the largest sum is 0x100FF.
  assign cksum_out = sum[15:0] + {15'b0, sum[16]};
  assign ttl_out   = ttl_in - 8'd1;

endmodule

// File: rtl/nf10_hdr_rewrite.sv
// rtl/nf10_hdr_rewrite.sv - next-hop Ethernet header rewrite after ARP lookup
// Purpose: forwarded IPv4 packets get new dst/src MAC, TTL-1, patched checksum
//          and the dst-port byte; ARP misses and expiring TTLs go to the CPU
//          queue of their source port; packets already carrying a dst-port
//          byte pass untouched. Optional macro HDR_REWRITE_STATS_EN adds
//          per-class 32-bit head counters.
// Ports:   AXI_ACLK, AXI_RESET (sync, active-high); s_axis packet in;
//          m_axis packet out; res_valid/res_ready/res_hit/res_oq/res_dmac
//          lookup results; mac0..mac3 own port MACs;
//          cnt_fwd/cnt_miss/cnt_ttl_exp/cnt_bypass (HDR_REWRITE_STATS_EN only).
module nf10_hdr_rewrite
  import router_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int SRC_PORT_POS         = 16,
  parameter int DST_PORT_POS         = 24,
  parameter int RES_FIFO_DEPTH_BITS  = 2
) (
  input  logic               AXI_ACLK,
  input  logic               AXI_RESET,
  nf10_hdr_rewrite_if.slave  s_axis,
  nf10_hdr_rewrite_if.master m_axis,
  input  logic               res_valid,
  output logic               res_ready,
  input  logic               res_hit,
  input  logic [7:0]         res_oq,
  input  logic [MAC_W-1:0]   res_dmac,
  input  logic [MAC_W-1:0]   mac0,
  input  logic [MAC_W-1:0]   mac1,
  input  logic [MAC_W-1:0]   mac2,
  input  logic [MAC_W-1:0]   mac3
`ifdef HDR_REWRITE_STATS_EN
  ,
  output logic [31:0]        cnt_fwd,
  output logic [31:0]        cnt_miss,
  output logic [31:0]        cnt_ttl_exp,
  output logic [31:0]        cnt_bypass
`endif
);

  localparam int STRB_W = C_S_AXIS_DATA_WIDTH / 8;
  localparam int PKT_W  = 1 + C_S_AXIS_TUSER_WIDTH + STRB_W + C_S_AXIS_DATA_WIDTH;
  localparam int RES_W  = 1 + 8 + MAC_W;

  logic [PKT_W-1:0]                pkt_dout;
  logic [C_S_AXIS_DATA_WIDTH-1:0]  in_data;
  logic [STRB_W-1:0]               in_strb;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] in_user;
  logic                            in_last;
  logic                            pkt_empty;
  logic                            pkt_nearly_full;

  logic [RES_W-1:0]                res_dout;
  logic                            r_hit;
  logic [7:0]                      r_oq;
  logic [MAC_W-1:0]                r_dmac;
  logic                            res_empty;
  logic                            res_full;
  logic                            res_rd;

  hdr_state_e                      state;
  logic [C_M_AXIS_TUSER_WIDTH-1:0] head_user_q;
  logic [C_M_AXIS_DATA_WIDTH-1:0]  out_data;
  logic [C_M_AXIS_TUSER_WIDTH-1:0] out_user;
  logic [MAC_W-1:0]                smac;
  logic [7:0]                      ttl_dec;
  logic [15:0]                     cksum_inc;
  logic                            is_head;
  logic                            bypass;
  logic                            fwd;
  logic                            can_emit;
  logic                            xfer;

  assign s_axis.tready = !pkt_nearly_full;
  assign res_ready     = !res_full && !AXI_RESET;

  fallthrough_small_fifo #(.WIDTH(PKT_W), .DEPTH_BITS(2), .PROG_FULL(3)) u_pkt_fifo (
    .clk         (AXI_ACLK),
    .reset       (AXI_RESET),
    .wr_en       (s_axis.tvalid && s_axis.tready),
    .din         ({s_axis.tlast, s_axis.tuser, s_axis.tstrb, s_axis.tdata}),
    .rd_en       (xfer),
    .dout        (pkt_dout),
    .nearly_full (pkt_nearly_full),
    .empty       (pkt_empty)
  );

  // Threshold equals the depth, so nearly_full is the true full flag here.
  fallthrough_small_fifo #(
    .WIDTH(RES_W), .DEPTH_BITS(RES_FIFO_DEPTH_BITS), .PROG_FULL(1 << RES_FIFO_DEPTH_BITS)
  ) u_res_fifo (
    .clk         (AXI_ACLK),
    .reset       (AXI_RESET),
    .wr_en       (res_valid && res_ready),
    .din         ({res_hit, res_oq, res_dmac}),
    .rd_en       (res_rd),
    .dout        (res_dout),
    .nearly_full (res_full),
    .empty       (res_empty)
  );

  assign {in_last, in_user, in_strb, in_data} = pkt_dout;
  assign {r_hit, r_oq, r_dmac}                = res_dout;

  ip_cksum_dec_ttl u_cksum (
    .ttl_in    (in_data[TTL_LO +: 8]),
    .cksum_in  (in_data[CKSUM_LO +: 16]),
    .ttl_out   (ttl_dec),
    .cksum_out (cksum_inc)
  );

  assign is_head  = (state == ST_HEAD);
  assign bypass   = (in_user[DST_PORT_POS +: 8] != 8'h00);
  assign fwd      = r_hit && (in_data[TTL_LO +: 8] > TTL_MIN);
  // A head that needs a lookup result stalls until one is queued.
  assign can_emit = !pkt_empty && !AXI_RESET && (!is_head || bypass || !res_empty);
  assign xfer     = can_emit && m_axis.tready;
  assign res_rd   = xfer && is_head && !bypass;

  // Even bit 2k of the one-hot port selects MAC port k; lowest wins.
  always_comb begin
    smac = mac0;
    if (r_oq[6]) smac = mac3;
    if (r_oq[4]) smac = mac2;
    if (r_oq[2]) smac = mac1;
    if (r_oq[0]) smac = mac0;
  end

  always_comb begin
    out_data = in_data;
    out_user = in_user;
    if (!is_head) begin
      out_user = head_user_q;
    end else if (!bypass) begin
      if (fwd) begin
        out_data[DMAC_LO +: MAC_W]  = r_dmac;
        out_data[SMAC_LO +: MAC_W]  = smac;
        out_data[TTL_LO +: 8]       = ttl_dec;
        out_data[CKSUM_LO +: 16]    = cksum_inc;
        out_user[DST_PORT_POS +: 8] = r_oq;
      end else begin
        // CPU queue sits one bit above its MAC port.
        out_user[DST_PORT_POS +: 8] = in_user[SRC_PORT_POS +: 8] << 1;
      end
    end
  end

  assign m_axis.tdata  = out_data;
  assign m_axis.tstrb  = in_strb;
  assign m_axis.tuser  = out_user;
  assign m_axis.tlast  = in_last;
  assign m_axis.tvalid = can_emit;

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET) begin
      state       <= ST_HEAD;
      head_user_q <= '0;
`ifdef HDR_REWRITE_STATS_EN
      cnt_fwd     <= '0;
      cnt_miss    <= '0;
      cnt_ttl_exp <= '0;
      cnt_bypass  <= '0;
`endif
    end else if (xfer) begin
      state <= in_last ? ST_HEAD : ST_BODY;
      if (is_head) begin
        head_user_q <= out_user;
`ifdef HDR_REWRITE_STATS_EN
        if (bypass)      cnt_bypass  <= cnt_bypass + 32'd1;
        else if (!r_hit) cnt_miss    <= cnt_miss + 32'd1;
        else if (!fwd)   cnt_ttl_exp <= cnt_ttl_exp + 32'd1;
        else             cnt_fwd     <= cnt_fwd + 32'd1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_nf10_hdr_rewrite.sv
// tb/tb_nf10_hdr_rewrite.sv - self-checking bench for nf10_hdr_rewrite
module tb_nf10_hdr_rewrite;

  typedef struct {
    logic [255:0] data;
    logic [31:0]  strb;
    logic [127:0] user;
    logic         last;
  } beat_t;

  typedef struct {
    logic        hit;
    logic [7:0]  oq;
    logic [47:0] dmac;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nf10_hdr_rewrite_if #(.DATA_WIDTH(256), .USER_WIDTH(128)) s_if ();
  nf10_hdr_rewrite_if #(.DATA_WIDTH(256), .USER_WIDTH(128)) m_if ();

  logic        res_valid;
  logic        res_ready;
  logic        res_hit;
  logic [7:0]  res_oq;
  logic [47:0] res_dmac;
  logic [47:0] macs [4];
`ifdef HDR_REWRITE_STATS_EN
  logic [31:0] cnt_fwd, cnt_miss, cnt_ttl_exp, cnt_bypass;
`endif

  nf10_hdr_rewrite dut (
    .AXI_ACLK  (clk),
    .AXI_RESET (rst),
    .s_axis    (s_if),
    .m_axis    (m_if),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_hit   (res_hit),
    .res_oq    (res_oq),
    .res_dmac  (res_dmac),
    .mac0      (macs[0]),
    .mac1      (macs[1]),
    .mac2      (macs[2]),
    .mac3      (macs[3])
`ifdef HDR_REWRITE_STATS_EN
    ,
    .cnt_fwd     (cnt_fwd),
    .cnt_miss    (cnt_miss),
    .cnt_ttl_exp (cnt_ttl_exp),
    .cnt_bypass  (cnt_bypass)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  beat_t exp_q[$];
  res_t  res_q[$];
  int rdy_mode  = 1;   // 0 random, 1 always ready, 2 never ready
  int res_delay = 0;   // <0: random 0..3 cycles
  int exp_cnt [4] = '{0, 0, 0, 0};  // fwd, miss, ttl_exp, bypass
  logic [255:0] last_head_data = '0;
  logic [127:0] last_head_user = '0;
  logic [255:0] last_sent_head = '0;
  logic mon_in_pkt = 1'b0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sink ready pattern.
  initial begin
    m_if.tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_if.tready = 1'($urandom_range(0, 1));
        1:       m_if.tready = 1'b1;
        default: m_if.tready = 1'b0;
      endcase
    end
  end

  // Output monitor against the reference queue.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst && m_if.tvalid && m_if.tready) begin
        check("beat_expected", 256'(exp_q.size() > 0), 256'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("tdata", m_if.tdata, e.data);
          check("tuser", 256'(m_if.tuser), 256'(e.user));
          check("tstrb", 256'(m_if.tstrb), 256'(e.strb));
          check("tlast", 256'(m_if.tlast), 256'(e.last));
        end
        if (!mon_in_pkt) begin
          last_head_data = m_if.tdata;
          last_head_user = m_if.tuser;
        end
        mon_in_pkt = !m_if.tlast;
      end
    end
  end

  // Lookup result driver.
  initial begin
    res_t r;
    int   d;
    bit   hs;
    res_valid = 1'b0; res_hit = 1'b0; res_oq = '0; res_dmac = '0;
    forever begin
      @(posedge clk); #1;
      if (res_q.size() > 0 && !rst) begin
        r = res_q[0];
        d = (res_delay < 0) ? int'($urandom_range(0, 3)) : res_delay;
        for (int i = 0; i < d; i++) begin @(posedge clk); #1; end
        res_valid = 1'b1; res_hit = r.hit; res_oq = r.oq; res_dmac = r.dmac;
        hs = 1'b0;
        for (int t = 0; t < 2000 && !hs; t++) begin
          @(negedge clk); hs = res_ready;
          @(posedge clk); #1;
        end
        check("res_handshake", 256'(hs), 256'(1));
        res_valid = 1'b0;
        void'(res_q.pop_front());
      end
    end
  end

  task automatic push_beat(input beat_t b);
    bit hs = 1'b0;
    s_if.tdata = b.data; s_if.tstrb = b.strb; s_if.tuser = b.user;
    s_if.tlast = b.last; s_if.tvalid = 1'b1;
    for (int t = 0; t < 2000 && !hs; t++) begin
      @(negedge clk); hs = s_if.tready;
      @(posedge clk); #1;
    end
    s_if.tvalid = 1'b0;
    check("s_handshake", 256'(hs), 256'(1));
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int w = 0; w < 8; w++) v[w*32 +: 32] = $urandom();
    return v;
  endfunction

  // Builds a packet, derives its expected output from the forwarding rules,
  // queues the lookup result if one is needed, then drives the beats.
  task automatic send_pkt(input int nbeats, input logic [7:0] ttl, input logic [15:0] ck,
                          input logic [7:0] src, input logic [7:0] dst, input logic hit,
                          input logic [7:0] oq, input logic [47:0] dmac, input int gap_max);
    beat_t pk[$];
    beat_t b;
    res_t  r;
    logic [127:0] ou;
    int cls, k, ck_i;
    for (int i = 0; i < nbeats; i++) begin
      b.data = rand256();
      b.strb = $urandom();
      b.user = {$urandom(), $urandom(), $urandom(), $urandom()};
      b.last = (i == nbeats - 1);
      pk.push_back(b);
    end
    pk[0].data[79:72]  = ttl;
    pk[0].data[63:48]  = ck;
    pk[0].user[23:16]  = src;
    pk[0].user[31:24]  = dst;
    last_sent_head     = pk[0].data;

    b  = pk[0];
    ou = b.user;
    if (dst != 8'h00)  cls = 3;
    else if (!hit)     cls = 1;
    else if (ttl <= 1) cls = 2;
    else               cls = 0;
    if (cls == 0) begin
      k = 0;
      for (int j = 0; j < 4; j++) if (oq[2*j]) k = j;
      ck_i = int'(ck) + 256;
      if (ck_i > 65535) ck_i = ck_i - 65535;
      b.data[255:208] = dmac;
      b.data[207:160] = macs[k];
      b.data[79:72]   = ttl - 8'd1;
      b.data[63:48]   = ck_i[15:0];
      ou[31:24]       = oq;
    end else if (cls != 3) begin
      ou[31:24] = 8'((int'(src) * 2) % 256);
    end
    exp_cnt[cls]++;
    b.user = ou;
    exp_q.push_back(b);
    for (int i = 1; i < nbeats; i++) begin
      b = pk[i];
      b.user = ou;
      exp_q.push_back(b);
    end
    if (dst == 8'h00) begin
      r.hit = hit; r.oq = oq; r.dmac = dmac;
      res_q.push_back(r);
    end
    for (int i = 0; i < nbeats; i++) begin
      push_beat(pk[i]);
      for (int g = $urandom_range(0, gap_max); g > 0; g--) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() > 0 || res_q.size() > 0) && t < 5000) begin
      @(posedge clk); #1; t++;
    end
    check("drain", 256'(exp_q.size() + res_q.size()), 256'(0));
  endtask

  task automatic send_random(input int gap_max);
    logic [63:0] dm;
    logic [7:0]  ttl, dst;
    logic [15:0] ck;
    dm  = {$urandom(), $urandom()};
    ttl = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom_range(0, 255));
    ck  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFE00, 16'hFFFF)) : 16'($urandom());
    dst = ($urandom_range(0, 4) == 0) ? (8'h02 << (2 * $urandom_range(0, 3))) : 8'h00;
    send_pkt($urandom_range(1, 4), ttl, ck, 8'h01 << (2 * $urandom_range(0, 3)), dst,
             1'($urandom_range(0, 3) != 0), 8'h01 << (2 * $urandom_range(0, 3)), dm[47:0], gap_max);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    beat_t hb;
    logic [31:0] fwd_snap;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tstrb = '0; s_if.tuser = '0; s_if.tlast = 1'b0;
    macs[0] = 48'h02AA00000010; macs[1] = 48'h001122334455;
    macs[2] = 48'h02CC00000030; macs[3] = 48'h02DD00000040;
    fwd_snap = '0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_tvalid", 256'(m_if.tvalid), 256'(0));
    check("rst_res_ready", 256'(res_ready), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_res_ready", 256'(res_ready), 256'(1));
    check("idle_s_tready", 256'(s_if.tready), 256'(1));
    check("idle_m_tvalid", 256'(m_if.tvalid), 256'(0));
`ifdef HDR_REWRITE_STATS_EN
    check("rst_cnt_fwd", 256'(cnt_fwd), 256'(0));
    check("rst_cnt_bypass", 256'(cnt_bypass), 256'(0));
`endif
    @(posedge clk); #1;

    // 1) forwarded hit
    rdy_mode = 1; res_delay = 0;
    send_pkt(2, 8'd64, 16'h1C46, 8'h01, 8'h00, 1'b1, 8'h04, 48'h0A0B0C0D0E0F, 0);
    wait_idle();
    check("t1_ttl", 256'(last_head_data[79:72]), 256'(8'd63));
    check("t1_cksum", 256'(last_head_data[63:48]), 256'(16'h1D46));
    check("t1_smac", 256'(last_head_data[207:160]), 256'(48'h001122334455));
    check("t1_dmac", 256'(last_head_data[255:208]), 256'(48'h0A0B0C0D0E0F));
    check("t1_dst_byte", 256'(last_head_user[31:24]), 256'(8'h04));

    // 2) checksum end-around carry
    send_pkt(1, 8'd20, 16'hFF00, 8'h04, 8'h00, 1'b1, 8'h10, 48'h111111111111, 0);
    wait_idle();
    check("t2_cksum", 256'(last_head_data[63:48]), 256'(16'h0001));

    // 3) ARP miss goes to the CPU queue, data untouched
    send_pkt(3, 8'd40, 16'h1234, 8'h10, 8'h00, 1'b0, 8'h01, 48'h222222222222, 0);
    wait_idle();
    check("t3_dst_byte", 256'(last_head_user[31:24]), 256'(8'h20));
    check("t3_data", last_head_data, last_sent_head);

    // 4) hit with TTL=1 is punted
    send_pkt(1, 8'd1, 16'hABCD, 8'h10, 8'h00, 1'b1, 8'h40, 48'h333333333333, 0);
    wait_idle();
    check("t4_dst_byte", 256'(last_head_user[31:24]), 256'(8'h20));
    check("t4_ttl", 256'(last_head_data[79:72]), 256'(8'd1));
    check("t4_data", last_head_data, last_sent_head);

    // bypass: dst-port byte already set
    send_pkt(2, 8'd9, 16'h0F0F, 8'h40, 8'h08, 1'b1, 8'h01, 48'h444444444444, 0);
    wait_idle();
    check("bypass_dst_byte", 256'(last_head_user[31:24]), 256'(8'h08));
    check("bypass_data", last_head_data, last_sent_head);

    // 5) three 4-beat packets back-to-back, late results, toggling ready
`ifdef HDR_REWRITE_STATS_EN
    fwd_snap = cnt_fwd;
`endif
    rdy_mode = 0; res_delay = 2;
    for (int p = 0; p < 3; p++)
      send_pkt(4, 8'd64, 16'($urandom()), 8'h01 << (2 * p), 8'h00, 1'b1,
               8'h01 << (2 * p), 48'h0A0B0C0D0E00 + 48'(p), 0);
    wait_idle();
`ifdef HDR_REWRITE_STATS_EN
    check("t5_fwd_delta", 256'(cnt_fwd - fwd_snap), 256'(3));
`endif

    // randomized traffic
    res_delay = -1;
    for (int p = 0; p < 40; p++) send_random(2);
    wait_idle();
`ifdef HDR_REWRITE_STATS_EN
    check("cnt_fwd", 256'(cnt_fwd), 256'(exp_cnt[0]));
    check("cnt_miss", 256'(cnt_miss), 256'(exp_cnt[1]));
    check("cnt_ttl_exp", 256'(cnt_ttl_exp), 256'(exp_cnt[2]));
    check("cnt_bypass", 256'(cnt_bypass), 256'(exp_cnt[3]));
`endif

    // 6) reset during beat 2 of a stalled, ready-to-go packet
    rdy_mode = 2; res_delay = 0;
    @(posedge clk); #1;
    begin
      res_t r;
      r.hit = 1'b1; r.oq = 8'h04; r.dmac = 48'h555555555555;
      res_q.push_back(r);
    end
    hb.data = rand256(); hb.strb = '1; hb.user = '0; hb.last = 1'b0;
    hb.data[79:72] = 8'd30;
    push_beat(hb);
    for (int t = 0; t < 100 && res_q.size() > 0; t++) begin @(posedge clk); #1; end
    @(negedge clk);
    check("t6_tvalid_before", 256'(m_if.tvalid), 256'(1));
    @(posedge clk); #1;
    s_if.tdata = rand256(); s_if.tlast = 1'b0; s_if.tvalid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("t6_tvalid_in_reset", 256'(m_if.tvalid), 256'(0));
    check("t6_res_ready_in_reset", 256'(res_ready), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0; s_if.tvalid = 1'b0;
    exp_cnt = '{0, 0, 0, 0};
    @(negedge clk);
    check("t6_tvalid_after", 256'(m_if.tvalid), 256'(0));
`ifdef HDR_REWRITE_STATS_EN
    check("t6_cnt_fwd_cleared", 256'(cnt_fwd), 256'(0));
`endif
    @(posedge clk); #1;
    rdy_mode = 0;
    send_pkt(3, 8'd10, 16'h8000, 8'h04, 8'h00, 1'b1, 8'h10, 48'h666666666666, 0);
    wait_idle();
    check("t6_next_ttl", 256'(last_head_data[79:72]), 256'(8'd9));
    check("t6_next_smac", 256'(last_head_data[207:160]), 256'(48'h02CC00000030));
`ifdef HDR_REWRITE_STATS_EN
    check("t6_cnt_fwd", 256'(cnt_fwd), 256'(exp_cnt[0]));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
